uart_xmit_fifo: RTL and testbench
=================================

Name: uart_xmit_fifo

Overview:
Transmit-side byte buffer placed directly upstream of the UART transmitter. It accepts bytes from the host through a write strobe, stores them in a FIFO, and presents them one at a time on the transmitter's xmitH/xmit_dataH inputs. Each byte is paced by the transmitter's xmit_doneH status, so a host can post a burst of bytes without waiting per byte.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries by default)
BUSY_TIMEOUT, 255, cycles to wait for xmit_doneH to drop after a launch before abandoning that byte

Ports:
sys_clk  input  1  system clock; all logic is on its rising edge
sys_rst  input  1  reset, synchronous, active-high
wr_en  input  1  host write strobe; one byte is accepted per cycle while high and not full
wr_data  input  8  host byte
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  DEPTH_LOG2+1  current occupancy
overflow  output  1  sticky; set by a write attempted while full
timeout_err  output  1  sticky; set when BUSY_TIMEOUT expires
xmitH  output  1  one-cycle launch pulse to the transmitter
xmit_dataH  output  8  byte being sent; stable from launch until the byte completes
xmit_doneH  input  1  transmitter status; high = idle/done, low = shifting

Behaviour:
- Reset: while sys_rst is high at a clock edge, all outputs clear on that edge.
  - full=0, empty=1, count=0, overflow=0, timeout_err=0, xmitH=0, xmit_dataH=0.
  - Pointers clear; state = IDLE.
  - Reset mid-transfer discards the FIFO contents and the in-flight byte.
- Storage: DEPTH = 2^DEPTH_LOG2 entries.
  - Read and write pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
  - count is held in its own register.
- Write: accepted when wr_en=1 and full=0; the byte is written at the write pointer and the pointer increments.
  - wr_en=1 while full=1: the byte is dropped and overflow is set. overflow clears only by reset.
- Simultaneous write and pop in one cycle: count is unchanged.
  - A write while full is rejected even if a pop happens in the same cycle; full is evaluated from the registered count.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if empty=0 and xmit_doneH=1, pop the head into xmit_dataH (the read pointer advances and count decrements on this edge). Next state LAUNCH.
  - LAUNCH: xmitH=1 for exactly this one cycle; the timeout counter loads 0. Next state WAIT_BUSY.
  - WAIT_BUSY: xmit_doneH=0 -> WAIT_DONE. Otherwise the counter increments; when it reaches BUSY_TIMEOUT, set timeout_err and go to IDLE (the byte is treated as lost).
  - WAIT_DONE: xmit_doneH=1 -> IDLE.
- xmit_dataH changes only on the IDLE->LAUNCH edge.
- Latency: a write into an empty FIFO with the transmitter idle gives xmitH high 2 cycles after the write edge (write edge, pop edge, pulse cycle).
- Back-to-back: the next launch needs at least one IDLE cycle after xmit_doneH returns high.
- The timeout counter is wide enough to reach BUSY_TIMEOUT; the counter does not wrap.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (2 bits).
  - Byte width constant (8).
  - Default DEPTH_LOG2 and BUSY_TIMEOUT values, shared with the receive-side buffer.
- Sub-module uart_sync_fifo holds the storage, pointers, count, full/empty and overflow.
  - Parameterised by DEPTH_LOG2 and width.
  - The receive path reuses it.
- The FSM and timeout counter live in uart_xmit_fifo.

Test Plan:
- Reset: hold sys_rst for 3 cycles mid-burst with 5 bytes queued -> next cycle count=0, empty=1, xmitH=0, xmit_dataH=0; no launch until a new write.
- Single byte: write 0xA5 with xmit_doneH=1 -> xmitH pulses 2 cycles later with xmit_dataH=0xA5; model drops xmit_doneH for 100 cycles -> no second xmitH; xmit_dataH holds 0xA5.
- Burst ordering: write 0x01..0x10 (16 bytes) back-to-back -> full=1 after the 16th accepted write (or one fewer if a pop occurred); transmitter model receives 0x01..0x10 in order, one xmitH per byte.
- Overflow: fill 16 with xmit_doneH=0, then write 0xFF -> overflow=1, count=16, 0xFF never transmitted.
- Simultaneous: count=3, wr_en on the same edge as the IDLE pop -> count stays 3; pointers wrap correctly across index 15->0.
- Timeout: xmit_doneH stuck at 1 after launch -> timeout_err=1 exactly BUSY_TIMEOUT cycles after the LAUNCH cycle; FSM returns to IDLE and launches the next queued byte.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART buffers
package uart_pkg;

    localparam int BYTE_W           = 8;
    localparam int DEF_DEPTH_LOG2   = 4;
    localparam int DEF_BUSY_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } xmit_state_t;

    // Smallest counter width that can hold max_val without wrapping
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_xmit_fifo_if.sv
// rtl/uart_xmit_fifo_if.sv - host write port, status and transmitter handshake bundle
interface uart_xmit_fifo_if import uart_pkg::*; #(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
);

    logic                  wr_en;
    logic [BYTE_W-1:0]     wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  timeout_err;
    logic                  xmitH;
    logic [BYTE_W-1:0]     xmit_dataH;
    logic                  xmit_doneH;

    // master: host plus transmitter side; slave: the buffer itself
    modport master (
        output wr_en, wr_data, xmit_doneH,
        input  full, empty, count, overflow, timeout_err, xmitH, xmit_dataH
    );

    modport slave (
        input  wr_en, wr_data, xmit_doneH,
        output full, empty, count, overflow, timeout_err, xmitH, xmit_dataH
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with registered occupancy and sticky overflow
module uart_sync_fifo import uart_pkg::*; #(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int WIDTH      = BYTE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // full comes from the registered count, so a pop in the same cycle does not free a slot
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_accept)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_xmit_fifo.sv
// rtl/uart_xmit_fifo.sv - transmit byte buffer pacing launches on the transmitter's done status
module uart_xmit_fifo import uart_pkg::*; #(
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    uart_xmit_fifo_if.slave bus
);

    localparam int CW = cnt_width(BUSY_TIMEOUT);
    localparam logic [CW-1:0] TMO_ONE  = CW'(1);
    localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TIMEOUT - 1);

    xmit_state_t           state;
    xmit_state_t           state_nxt;
    logic [CW-1:0]         tmo_cnt;
    logic [CW-1:0]         tmo_cnt_nxt;
    logic                  pop;
    logic                  launch;
    logic                  tmo_set;
    logic [BYTE_W-1:0]     head;
    logic [BYTE_W-1:0]     data_q;
    logic                  tmo_err_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_overflow;

    uart_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (BYTE_W)
    ) u_fifo (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .wr_en    (bus.wr_en),
        .wr_data  (bus.wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_overflow)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            data_q    <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (pop)
                data_q <= head;
            if (tmo_set)
                tmo_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        pop         = 1'b0;
        launch      = 1'b0;
        tmo_set     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && bus.xmit_doneH) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                launch      = 1'b1;
                tmo_cnt_nxt = '0;
                state_nxt   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.xmit_doneH) begin
                    state_nxt = WAIT_DONE;
                end else begin
                    // Flag is raised on the edge the counter reaches BUSY_TIMEOUT; the byte is abandoned
                    tmo_cnt_nxt = tmo_cnt + TMO_ONE;
                    if (tmo_cnt == TMO_LAST) begin
                        tmo_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.xmit_doneH)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.full        = fifo_full;
    assign bus.empty       = fifo_empty;
    assign bus.count       = fifo_count;
    assign bus.overflow    = fifo_overflow;
    assign bus.timeout_err = tmo_err_q;
    assign bus.xmitH       = launch;
    assign bus.xmit_dataH  = data_q;

endmodule

// File: tb/tb_uart_xmit_fifo.sv
// tb/tb_uart_xmit_fifo.sv - directed self-checking bench for uart_xmit_fifo
module tb_uart_xmit_fifo;

    localparam int DL2 = 4;
    localparam int BT  = 255;

    logic clk;
    logic rst;
    logic model_on;
    logic model_done;
    logic manual_done;
    int   busy_len;
    int   busy_left;
    int   launches;
    logic [7:0] rx_q [$];
    int   checks;
    int   errors;

    uart_xmit_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

    uart_xmit_fifo #(
        .DEPTH_LOG2   (DL2),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    assign bus.xmit_doneH = model_on ? model_done : manual_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: logs every launch, goes busy for busy_len cycles when enabled
    always @(negedge clk) begin
        if (rst) begin
            busy_left  = 0;
            model_done = 1'b1;
        end else begin
            if (bus.xmitH) begin
                rx_q.push_back(bus.xmit_dataH);
                launches++;
            end
            if (model_on) begin
                if (bus.xmitH) begin
                    model_done = 1'b0;
                    busy_left  = busy_len;
                end else if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0)
                        model_done = 1'b1;
                end
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = start + 8'(i);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_launches(input int target, input int budget);
        for (int i = 0; i < budget && launches < target; i++)
            @(negedge clk);
        checks++;
        if (launches < target) begin
            errors++;
            $display("FAIL launch_wait: got %0d launches, expected %0d", launches, target);
        end
    endtask

    task automatic test_reset;
        do_reset(3);
        checks++; if (bus.count !== 5'd0)        begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1)        begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.full !== 1'b0)         begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.overflow !== 1'b0)     begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.timeout_err !== 1'b0)  begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout_err); end
        checks++; if (bus.xmitH !== 1'b0)        begin errors++; $display("FAIL reset_xmit: got %b expected 0", bus.xmitH); end
        checks++; if (bus.xmit_dataH !== 8'h00)  begin errors++; $display("FAIL reset_data: got %h expected 00", bus.xmit_dataH); end
    endtask

    task automatic test_reset_mid_burst;
        int base;
        model_on    = 1'b0;
        manual_done = 1'b1;
        write_burst(8'h11, 5);
        checks++; if (bus.count !== 5'd4)       begin errors++; $display("FAIL midrst_pre_count: got %0d expected 4", bus.count); end
        checks++; if (bus.xmit_dataH !== 8'h11) begin errors++; $display("FAIL midrst_pre_data: got %h expected 11", bus.xmit_dataH); end
        do_reset(3);
        checks++; if (bus.count !== 5'd0)       begin errors++; $display("FAIL midrst_count: got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1)       begin errors++; $display("FAIL midrst_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.xmitH !== 1'b0)       begin errors++; $display("FAIL midrst_xmit: got %b expected 0", bus.xmitH); end
        checks++; if (bus.xmit_dataH !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", bus.xmit_dataH); end
        base = launches;
        repeat (20) @(negedge clk);
        checks++; if (launches !== base)        begin errors++; $display("FAIL midrst_no_launch: got %0d launches expected %0d", launches, base); end
    endtask

    task automatic test_single_byte;
        int base;
        do_reset(2);
        model_on = 1'b1;
        busy_len = 100;
        base     = launches;
        write_burst(8'hA5, 1);
        checks++; if (bus.xmitH !== 1'b0)       begin errors++; $display("FAIL single_early: got %b expected 0", bus.xmitH); end
        @(negedge clk);
        checks++; if (bus.xmitH !== 1'b1)       begin errors++; $display("FAIL single_launch: got %b expected 1", bus.xmitH); end
        checks++; if (bus.xmit_dataH !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", bus.xmit_dataH); end
        repeat (60) @(negedge clk);
        checks++; if (launches !== base + 1)    begin errors++; $display("FAIL single_one_launch: got %0d expected %0d", launches - base, 1); end
        checks++; if (bus.xmit_dataH !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h expected a5", bus.xmit_dataH); end
        repeat (60) @(negedge clk);
        checks++; if (launches !== base + 1)    begin errors++; $display("FAIL single_after_done: got %0d expected %0d", launches - base, 1); end
        model_on = 1'b0;
    endtask

    task automatic test_burst;
        int base;
        int rbase;
        do_reset(2);
        model_on    = 1'b0;
        manual_done = 1'b0;
        write_burst(8'h01, 16);
        checks++; if (bus.full !== 1'b1)   begin errors++; $display("FAIL burst_full: got %b expected 1", bus.full); end
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL burst_count: got %0d expected 16", bus.count); end
        base     = launches;
        rbase    = rx_q.size();
        busy_len = 3;
        model_on = 1'b1;
        wait_launches(base + 16, 400);
        repeat (20) @(negedge clk);
        checks++; if (launches !== base + 16) begin errors++; $display("FAIL burst_launches: got %0d expected 16", launches - base); end
        for (int i = 0; i < 16 && rbase + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[rbase + i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL burst_order[%0d]: got %h expected %h", i, rx_q[rbase + i], 8'(i + 1));
            end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL burst_drained: got %b expected 1", bus.empty); end
        model_on = 1'b0;
    endtask

    task automatic test_overflow;
        int base;
        int rbase;
        do_reset(2);
        model_on    = 1'b0;
        manual_done = 1'b0;
        write_burst(8'h20, 16);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", bus.overflow); end
        write_burst(8'hFF, 1);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
        checks++; if (bus.count !== 5'd16)   begin errors++; $display("FAIL ovf_count: got %0d expected 16", bus.count); end
        base     = launches;
        rbase    = rx_q.size();
        busy_len = 2;
        model_on = 1'b1;
        wait_launches(base + 16, 400);
        repeat (20) @(negedge clk);
        checks++; if (launches !== base + 16) begin errors++; $display("FAIL ovf_launches: got %0d expected 16", launches - base); end
        for (int i = 0; i < 16 && rbase + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[rbase + i] !== 8'h20 + 8'(i)) begin
                errors++;
                $display("FAIL ovf_order[%0d]: got %h expected %h", i, rx_q[rbase + i], 8'h20 + 8'(i));
            end
        end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
        model_on = 1'b0;
    endtask

    task automatic test_simultaneous;
        int base;
        int rbase;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h61; exp_b[1] = 8'h62; exp_b[2] = 8'h63; exp_b[3] = 8'h64;
        do_reset(2);
        busy_len = 2;
        model_on = 1'b1;
        base     = launches;
        write_burst(8'h40, 13);
        wait_launches(base + 13, 300);
        repeat (10) @(negedge clk);
        model_on    = 1'b0;
        manual_done = 1'b0;
        write_burst(8'h61, 3);
        checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL simul_pre_count: got %0d expected 3", bus.count); end
        base        = launches;
        rbase       = rx_q.size();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h64;
        model_on    = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        checks++; if (bus.count !== 5'd3)       begin errors++; $display("FAIL simul_count: got %0d expected 3", bus.count); end
        checks++; if (bus.xmit_dataH !== 8'h61) begin errors++; $display("FAIL simul_pop: got %h expected 61", bus.xmit_dataH); end
        wait_launches(base + 4, 200);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4 && rbase + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[rbase + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL simul_wrap[%0d]: got %h expected %h", i, rx_q[rbase + i], exp_b[i]);
            end
        end
        model_on = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset(2);
        model_on    = 1'b0;
        manual_done = 1'b0;
        write_burst(8'h77, 1);
        write_burst(8'h88, 1);
        manual_done = 1'b1;
        @(negedge clk);
        checks++; if (bus.xmitH !== 1'b1)       begin errors++; $display("FAIL tmo_launch: got %b expected 1", bus.xmitH); end
        checks++; if (bus.xmit_dataH !== 8'h77) begin errors++; $display("FAIL tmo_data: got %h expected 77", bus.xmit_dataH); end
        repeat (BT) @(negedge clk);
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0", bus.timeout_err); end
        @(negedge clk);
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_set: got %b expected 1", bus.timeout_err); end
        @(negedge clk);
        checks++; if (bus.xmitH !== 1'b1)       begin errors++; $display("FAIL tmo_next_launch: got %b expected 1", bus.xmitH); end
        checks++; if (bus.xmit_dataH !== 8'h88) begin errors++; $display("FAIL tmo_next_data: got %h expected 88", bus.xmit_dataH); end
        do_reset(2);
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", bus.timeout_err); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        launches    = 0;
        busy_len    = 2;
        busy_left   = 0;
        model_on    = 1'b0;
        model_done  = 1'b1;
        manual_done = 1'b1;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        @(negedge clk);
        test_reset;
        test_reset_mid_burst;
        test_single_byte;
        test_burst;
        test_overflow;
        test_simultaneous;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
